// File: rtl/bp_pht_pkg.sv
// Shared definitions for the pattern history table write-side controller.
// Holds the controller state encoding, the default initialisation value and
// the saturating counter helpers used for training read-modify-writes.
package bp_pht_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } pht_state_e;

  // 1 = weakly not-taken for a 2-bit counter
  localparam int unsigned PHT_INIT_DFLT = 1;

  // Counters up to 32 bits wide; w selects the live width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] mx;
    mx = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= mx) ? mx : (v + 32'd1);
  endfunction

  function automatic logic [31:0] sat_dec(input logic [31:0] v);
    return (v == '0) ? '0 : (v - 32'd1);
  endfunction

endpackage

// File: rtl/bp_pht_table.sv
// PHT storage: p_entries enable registers of p_nbits each, no functional
// reset (contents are established by the controller's init walk).
// Ports:
//   clk        clock
//   tbl_wen    write enable for this cycle
//   tbl_widx   entry written / read
//   tbl_wdata  data written
//   tbl_rdata  combinational read of entry tbl_widx
module bp_pht_table #(
  parameter int unsigned p_entries = 16,
  parameter int unsigned p_nbits   = 2,
  localparam int unsigned IW       = (p_entries > 1) ? $clog2(p_entries) : 1
) (
  input  logic               clk,
  input  logic               tbl_wen,
  input  logic [IW-1:0]      tbl_widx,
  input  logic [p_nbits-1:0] tbl_wdata,
  output logic [p_nbits-1:0] tbl_rdata
);

  logic [p_nbits-1:0] mem_q [p_entries];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < p_entries; i++) begin
      if (tbl_wen && (tbl_widx == IW'(i))) begin
        mem_q[i] <= tbl_wdata;
      end
    end
  end

  assign tbl_rdata = mem_q[tbl_widx];

endmodule

// File: rtl/bp_pht_ctrl.sv
// Write-side controller for the PHT. After reset or a clear it walks the
// table writing p_init to one entry per cycle (INIT); afterwards it performs
// one training read-modify-write per cycle (RUN).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   upd_val/upd_rdy       training update handshake (upd_idx, upd_taken)
//   clr_val/clr_rdy       table re-initialise handshake
//   tbl_rdata             combinational read of entry tbl_widx
//   tbl_wen/widx/wdata    table write port
//   busy                  initialisation in progress
//   upd_count             updates accepted since last reset or clear
module bp_pht_ctrl
  import bp_pht_pkg::*;
#(
  parameter int unsigned p_entries = 16,
  parameter int unsigned p_nbits   = 2,
  parameter int unsigned p_init    = PHT_INIT_DFLT,
  parameter int unsigned p_cbits   = 16,
  localparam int unsigned IW       = (p_entries > 1) ? $clog2(p_entries) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               upd_val,
  output logic               upd_rdy,
  input  logic [IW-1:0]      upd_idx,
  input  logic               upd_taken,
  input  logic               clr_val,
  output logic               clr_rdy,
  input  logic [p_nbits-1:0] tbl_rdata,
  output logic               tbl_wen,
  output logic [IW-1:0]      tbl_widx,
  output logic [p_nbits-1:0] tbl_wdata,
  output logic               busy,
  output logic [p_cbits-1:0] upd_count
);

  pht_state_e         state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [p_cbits-1:0] cnt_q, cnt_d;
  logic [p_nbits-1:0] rmw;

  always_comb begin
    rmw = upd_taken ? p_nbits'(sat_inc(32'(tbl_rdata), p_nbits))
                    : p_nbits'(sat_dec(32'(tbl_rdata)));
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    upd_rdy   = 1'b0;
    clr_rdy   = 1'b0;
    tbl_wen   = 1'b0;
    tbl_widx  = '0;
    tbl_wdata = '0;
    busy      = 1'b0;
    unique case (state_q)
      INIT: begin
        tbl_wen   = 1'b1;
        tbl_widx  = idx_q;
        tbl_wdata = p_nbits'(p_init);
        busy      = 1'b1;
        idx_d     = idx_q + 1'b1;
        if (idx_q == IW'(p_entries - 1)) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        upd_rdy   = 1'b1;
        clr_rdy   = 1'b1;
        tbl_widx  = upd_idx;
        tbl_wen   = upd_val;
        tbl_wdata = rmw;
        if (upd_val) begin
          cnt_d = cnt_q + 1'b1;
        end
        // A clear wins the counter even when an update fires alongside it;
        // the update's table write still happens this cycle.
        if (clr_val) begin
          state_d = INIT;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
    // Outputs are held quiet while reset is asserted; busy reflects INIT.
    if (reset) begin
      upd_rdy   = 1'b0;
      clr_rdy   = 1'b0;
      tbl_wen   = 1'b0;
      tbl_widx  = '0;
      tbl_wdata = '0;
      busy      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign upd_count = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_bp_pht_ctrl.sv
module tb_bp_pht_ctrl;

  localparam int unsigned NE = 16;
  localparam int unsigned NB = 2;
  localparam int unsigned CB = 16;
  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          upd_val, upd_rdy, upd_taken, clr_val, clr_rdy;
  logic [IW-1:0] upd_idx, tbl_widx;
  logic [NB-1:0] tbl_rdata, tbl_wdata;
  logic          tbl_wen, busy;
  logic [CB-1:0] upd_count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  bp_pht_ctrl #(.p_entries(NE), .p_nbits(NB), .p_init(1), .p_cbits(CB)) dut (
    .clk(clk), .reset(reset),
    .upd_val(upd_val), .upd_rdy(upd_rdy), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .clr_val(clr_val), .clr_rdy(clr_rdy),
    .tbl_rdata(tbl_rdata), .tbl_wen(tbl_wen), .tbl_widx(tbl_widx), .tbl_wdata(tbl_wdata),
    .busy(busy), .upd_count(upd_count)
  );

  bp_pht_table #(.p_entries(NE), .p_nbits(NB)) u_tbl (
    .clk(clk), .tbl_wen(tbl_wen), .tbl_widx(tbl_widx),
    .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata)
  );

  // Start a new cycle: inputs change mid-cycle, outputs settle 1 ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    upd_val = 1'b0; clr_val = 1'b0; upd_taken = 1'b0; upd_idx = '0;
  endtask

  // Walk of NE cycles after a reset drop or clear acceptance; caller is
  // positioned just before cycle 0 of the walk.
  task automatic check_walk(input string tag);
    for (int unsigned c = 0; c < NE; c++) begin
      next_cycle(); #1;
      n_vec++;
      if ({busy, tbl_wen, upd_rdy, clr_rdy} !== 4'b1100 || tbl_widx !== IW'(c) ||
          tbl_wdata !== 2'd1 || upd_count !== '0) begin
        n_err++;
        $display("FAIL %s cyc %0d: busy=%b wen=%b urdy=%b crdy=%b widx=%0d wdata=%0d cnt=%0d, want 1 1 0 0 %0d 1 0",
                 tag, c, busy, tbl_wen, upd_rdy, clr_rdy, tbl_widx, tbl_wdata, upd_count, c);
      end
    end
    next_cycle(); #1;
    n_vec++;
    if (busy !== 1'b0 || upd_rdy !== 1'b1 || clr_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL %s run_entry: busy=%b urdy=%b crdy=%b, want 0 1 1", tag, busy, upd_rdy, clr_rdy);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) next_cycle();
    #1;
    n_vec++;
    if ({busy, upd_rdy, clr_rdy, tbl_wen} !== 4'b1000 || tbl_widx !== '0 ||
        tbl_wdata !== '0 || upd_count !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: busy=%b urdy=%b crdy=%b wen=%b widx=%0d wdata=%0d cnt=%0d, want 1 0 0 0 0 0 0",
               busy, upd_rdy, clr_rdy, tbl_wen, tbl_widx, tbl_wdata, upd_count);
    end
    // reset drops at the start of the following cycle (cycle 0)
    @(negedge clk); reset = 1'b0; #1;
    n_vec++;
    if (busy !== 1'b1 || tbl_widx !== '0 || tbl_wen !== 1'b1) begin
      n_err++;
      $display("FAIL init_cyc0: busy=%b widx=%0d wen=%b, want 1 0 1", busy, tbl_widx, tbl_wen);
    end
    for (int unsigned c = 1; c < NE; c++) begin
      next_cycle(); #1;
      n_vec++;
      if (busy !== 1'b1 || tbl_widx !== IW'(c) || upd_rdy !== 1'b0 || tbl_wdata !== 2'd1) begin
        n_err++;
        $display("FAIL init_walk cyc %0d: busy=%b widx=%0d urdy=%b wdata=%0d, want 1 %0d 0 1",
                 c, busy, tbl_widx, upd_rdy, tbl_wdata, c);
      end
    end
    next_cycle(); #1;
    n_vec++;
    if (upd_rdy !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL init_done cyc16: urdy=%b busy=%b, want 1 0", upd_rdy, busy);
    end
    for (int unsigned e = 0; e < NE; e++) begin
      upd_idx = IW'(e); #1;
      n_vec++;
      if (tbl_rdata !== 2'd1 || tbl_wen !== 1'b0) begin
        n_err++;
        $display("FAIL init_entry %0d: rdata=%0d wen=%b, want 1 0", e, tbl_rdata, tbl_wen);
      end
    end
  endtask

  task automatic test_sat_up();
    logic [NB-1:0] exp_rd [4];
    logic [NB-1:0] exp_wd [4];
    exp_rd = '{2'd1, 2'd2, 2'd3, 2'd3};
    exp_wd = '{2'd2, 2'd3, 2'd3, 2'd3};
    for (int unsigned k = 0; k < 4; k++) begin
      next_cycle();
      upd_val = 1'b1; upd_idx = 4'd5; upd_taken = 1'b1; #1;
      n_vec++;
      if (tbl_wen !== 1'b1 || tbl_widx !== 4'd5 || tbl_rdata !== exp_rd[k] || tbl_wdata !== exp_wd[k]) begin
        n_err++;
        $display("FAIL sat_up %0d: wen=%b widx=%0d rdata=%0d wdata=%0d, want 1 5 %0d %0d",
                 k, tbl_wen, tbl_widx, tbl_rdata, tbl_wdata, exp_rd[k], exp_wd[k]);
      end
    end
    next_cycle(); idle_inputs(); upd_idx = 4'd5; #1;
    n_vec++;
    if (tbl_rdata !== 2'd3 || upd_count !== 16'd4) begin
      n_err++;
      $display("FAIL sat_up_final: rdata=%0d cnt=%0d, want 3 4", tbl_rdata, upd_count);
    end
  endtask

  task automatic test_sat_down();
    logic [NB-1:0] exp_rd [3];
    exp_rd = '{2'd1, 2'd0, 2'd0};
    for (int unsigned k = 0; k < 3; k++) begin
      next_cycle();
      upd_val = 1'b1; upd_idx = 4'd0; upd_taken = 1'b0; #1;
      n_vec++;
      if (tbl_wen !== 1'b1 || tbl_rdata !== exp_rd[k] || tbl_wdata !== 2'd0) begin
        n_err++;
        $display("FAIL sat_down %0d: wen=%b rdata=%0d wdata=%0d, want 1 %0d 0",
                 k, tbl_wen, tbl_rdata, tbl_wdata, exp_rd[k]);
      end
    end
    next_cycle(); idle_inputs(); upd_idx = 4'd0; #1;
    n_vec++;
    if (tbl_rdata !== 2'd0 || upd_count !== 16'd7) begin
      n_err++;
      $display("FAIL sat_down_final: rdata=%0d cnt=%0d, want 0 7", tbl_rdata, upd_count);
    end
  endtask

  task automatic test_upd_clr();
    next_cycle();
    upd_val = 1'b1; upd_idx = 4'd3; upd_taken = 1'b1; clr_val = 1'b1; #1;
    n_vec++;
    if (upd_rdy !== 1'b1 || clr_rdy !== 1'b1 || tbl_wen !== 1'b1 || tbl_widx !== 4'd3 || tbl_wdata !== 2'd2) begin
      n_err++;
      $display("FAIL upd_clr_accept: urdy=%b crdy=%b wen=%b widx=%0d wdata=%0d, want 1 1 1 3 2",
               upd_rdy, clr_rdy, tbl_wen, tbl_widx, tbl_wdata);
    end
    // drop valids before the walk begins
    @(posedge clk); #1; idle_inputs();
    check_walk("upd_clr_walk");
    upd_idx = 4'd3; #1;
    n_vec++;
    if (tbl_rdata !== 2'd1 || upd_count !== '0) begin
      n_err++;
      $display("FAIL upd_clr_entry3: rdata=%0d cnt=%0d, want 1 0", tbl_rdata, upd_count);
    end
    upd_idx = 4'd5; #1;
    n_vec++;
    if (tbl_rdata !== 2'd1) begin
      n_err++;
      $display("FAIL upd_clr_entry5: rdata=%0d, want 1", tbl_rdata);
    end
  endtask

  task automatic test_upd_during_init();
    int unsigned waited;
    bit done;
    next_cycle(); clr_val = 1'b1; #1;
    @(posedge clk); #1;
    clr_val = 1'b0; upd_val = 1'b1; upd_idx = 4'd7; upd_taken = 1'b1;
    waited = 0; done = 1'b0;
    while (!done && waited < 40) begin
      next_cycle(); #1;
      if (upd_rdy === 1'b1) begin
        done = 1'b1;
      end else begin
        waited++;
        n_vec++;
        if (tbl_wen !== 1'b1 || tbl_wdata !== 2'd1) begin
          n_err++;
          $display("FAIL init_hold wen/wdata cyc %0d: wen=%b wdata=%0d, want 1 1", waited, tbl_wen, tbl_wdata);
        end
      end
    end
    n_vec++;
    if (!done || waited != NE) begin
      n_err++;
      $display("FAIL init_hold_latency: rdy_seen=%b waited=%0d, want 1 %0d", done, waited, NE);
    end
    n_vec++;
    if (tbl_wen !== 1'b1 || tbl_widx !== 4'd7 || tbl_rdata !== 2'd1 || tbl_wdata !== 2'd2) begin
      n_err++;
      $display("FAIL init_hold_fire: wen=%b widx=%0d rdata=%0d wdata=%0d, want 1 7 1 2",
               tbl_wen, tbl_widx, tbl_rdata, tbl_wdata);
    end
    next_cycle(); idle_inputs(); upd_idx = 4'd7; #1;
    n_vec++;
    if (tbl_rdata !== 2'd2 || upd_count !== 16'd1) begin
      n_err++;
      $display("FAIL init_hold_after: rdata=%0d cnt=%0d, want 2 1", tbl_rdata, upd_count);
    end
  endtask

  task automatic test_reset_mid_walk();
    int unsigned waited;
    bit found;
    next_cycle(); clr_val = 1'b1; #1;
    @(posedge clk); #1; clr_val = 1'b0;
    waited = 0; found = 1'b0;
    while (!found && waited < 40) begin
      next_cycle(); #1;
      waited++;
      if (busy === 1'b1 && tbl_widx === 4'd9) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL mid_walk_reach: widx 9 not seen within %0d cycles", waited);
    end
    next_cycle(); reset = 1'b1; #1;
    n_vec++;
    if (busy !== 1'b1 || tbl_wen !== 1'b0 || tbl_widx !== '0 || upd_count !== '0) begin
      n_err++;
      $display("FAIL mid_walk_in_reset: busy=%b wen=%b widx=%0d cnt=%0d, want 1 0 0 0",
               busy, tbl_wen, tbl_widx, upd_count);
    end
    @(posedge clk); #1; reset = 1'b0;
    check_walk("mid_walk_restart");
    n_vec++;
    if (upd_count !== '0) begin
      n_err++;
      $display("FAIL mid_walk_count: cnt=%0d, want 0", upd_count);
    end
  endtask

  initial begin
    test_reset();
    test_sat_up();
    test_sat_down();
    test_upd_clr();
    test_upd_during_init();
    test_reset_mid_walk();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, want completion before 200000");
    $fatal(1);
  end

endmodule
